aux_keypad: RTL and testbench
=============================

Name: aux_keypad

Overview:
- Input-side counterpart of the auxiliary 7-segment display: scans a 4x4 active-low hex keypad, debounces it, and reports each new key press as a one-cycle strobe with a 4-bit code.
- Shifts every accepted hex digit into a 32-bit entry register whose output feeds the display's 32-bit data input directly.
- Sits in the board-level aux I/O next to the display; all logic runs in one clock domain.

Parameters:
- ScanCntMax, 100000, clk cycles per column dwell (1 ms at 100 MHz); the scan tick fires once per dwell.
- DebounceScans, 4, consecutive identical full sweeps required to accept a press or a release; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset; all flops reset on its falling edge, no clock needed
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_n  output  4  keypad column drive, one-cold, registered
- clr  input  1  synchronous clear of data
- key_valid  output  1  one-cycle press strobe
- key_code  output  4  code of the last accepted key, held until the next press
- data  output  32  entry register, newest digit in [3:0]

Behaviour:
- Reset values: col_n=4'b1110, key_valid=0, key_code=0, data=0, FSM=IDLE, divider count=0, column index=0, sweep accumulator cleared.
- Synchronizer: row_n goes through 2 flops before any use.
- Scan tick: divider counts 0..ScanCntMax-1 and asserts tick for one cycle when the count equals ScanCntMax-1, then wraps to 0.
- Column scan: on each tick, sample the synchronized rows for the current column (index c), then advance c=(c+1) mod 4 and drive col_n=~(1<<c) on the next cycle.
- Sweep: the tick that samples column 3 ends a sweep.
- Per-sweep candidate:
  - Exactly one pressed switch in the sweep (row r, col c) gives a candidate with code = 4*r + c.
  - Zero pressed switches gives NONE.
  - Two or more pressed switches (ghosting) is treated as NONE.
- FSM, evaluated only at sweep end; the debounce counter is 4 bits:
  - IDLE: candidate is a key K -> DEB_PRESS, cand=K, cnt=1. If DebounceScans==1, go directly to HELD and fire the strobe.
  - DEB_PRESS: candidate==cand -> cnt++. When cnt reaches DebounceScans, fire the strobe and go to HELD. Any other candidate (different key or NONE) -> IDLE.
  - HELD: candidate NONE -> DEB_REL, cnt=1 (or IDLE directly if DebounceScans==1). Any key (same or different) stays in HELD. No auto-repeat and no roll-over: a new key requires a full release first.
  - DEB_REL: NONE -> cnt++. At DebounceScans -> IDLE. Any key -> HELD with no new strobe.
- Strobe (press accepted):
  - key_valid=1 for exactly one cycle, in the cycle after the sweep-end tick.
  - key_code <= cand in the same cycle.
  - data <= {data[27:0], cand}; the top digit is discarded.
- Latency: the press strobe follows the end of the DebounceScans-th matching sweep by 1 cycle.
- clr: data <= 0 on the next edge. It takes precedence over a same-cycle shift; key_valid and key_code still update. clr does not affect the FSM or the scan.
- Reset asserted mid-operation: all state returns to reset values immediately. A key held through reset release must complete the full press debounce again before it is accepted.

Decomposition:
- Shared header holds:
  - FSM state encodings KP_IDLE, KP_DEB_PRESS, KP_HELD, KP_DEB_REL (2 bits)
  - the CNT_MILLISEC millisecond count macro used for the ScanCntMax default
- One natural sub-module, keypad_debounce: the sweep-end FSM plus debounce counter. Its inputs are the candidate valid/code and the sweep-end tick; its outputs are the press strobe and the code.
- Scanning, synchronization and the data register stay in aux_keypad.

Test Plan:
Bench parameters: ScanCntMax=4, DebounceScans=2; the keypad model drives row_n low for a pressed switch whenever its column is driven.
- Hold row 1/col 2 (code 6) for 3 sweeps -> exactly one key_valid pulse, 1 cycle after the 2nd sweep end; key_code=4'h6; data=32'h00000006.
- Press and release codes 1, 2, 3 in turn, each held and released for 3 sweeps -> 3 pulses; data=32'h00000123.
- Press code 5 for 1 sweep, release, then press for 3 sweeps -> the 1-sweep bounce is ignored and exactly one pulse occurs afterward.
- Hold code 0 and code 5 together for 4 sweeps -> no pulse; data unchanged.
- Hold code 4 for 10 sweeps -> a single pulse (no repeat); insert a 1-sweep release glitch -> still no new pulse.
- Enter 9 digits 1..9 -> data=32'h23456789. Assert clr in the same cycle as a strobe -> data=0 and key_code updated. Assert rst_n=0 mid-DEB_PRESS -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/aux_keypad_pkg.sv
// Shared definitions for the auxiliary hex keypad: debounce FSM states and scan helpers.
`ifndef CNT_MILLISEC
`define CNT_MILLISEC 100000
`endif

package aux_keypad_pkg;

  typedef enum logic [1:0] {
    KP_IDLE      = 2'd0,
    KP_DEB_PRESS = 2'd1,
    KP_HELD      = 2'd2,
    KP_DEB_REL   = 2'd3
  } kp_state_e;

  // Number of pressed rows in one column, saturated at 2 (anything above one is ghosting).
  function automatic logic [1:0] kp_hit_count(input logic [3:0] pressed);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, pressed[i]};
    end
    if (n > 3'd1) begin
      return 2'd2;
    end else begin
      return n[1:0];
    end
  endfunction

  function automatic logic [1:0] kp_sat_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > 3'd1) begin
      return 2'd2;
    end else begin
      return s[1:0];
    end
  endfunction

  function automatic logic [1:0] kp_row_index(input logic [3:0] pressed);
    if (pressed[0]) begin
      return 2'd0;
    end else if (pressed[1]) begin
      return 2'd1;
    end else if (pressed[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Sweep-end debounce FSM: accepts a key after DebounceScans matching sweeps and
// requires the same number of empty sweeps before another press can be accepted.
module keypad_debounce
  import aux_keypad_pkg::*;
#(
  parameter int unsigned DebounceScans = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sweep_end_i,
  input  logic       cand_valid_i,
  input  logic [3:0] cand_code_i,
  output logic       press_o,
  output logic [3:0] code_o
);

  localparam logic [3:0] DebN = 4'(DebounceScans);

  kp_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;

  // State, debounce count and candidate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KP_IDLE;
      cnt_q   <= 4'd0;
      cand_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Next-state logic; only a sweep end can move the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    press_o = 1'b0;
    code_o  = (state_q == KP_IDLE) ? cand_code_i : cand_q;
    if (sweep_end_i) begin
      case (state_q)
        KP_IDLE: begin
          if (cand_valid_i) begin
            cand_d = cand_code_i;
            cnt_d  = 4'd1;
            if (DebN == 4'd1) begin
              state_d = KP_HELD;
              press_o = 1'b1;
            end else begin
              state_d = KP_DEB_PRESS;
            end
          end else begin
            state_d = KP_IDLE;
          end
        end
        KP_DEB_PRESS: begin
          if (cand_valid_i && (cand_code_i == cand_q)) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == DebN) begin
              state_d = KP_HELD;
              press_o = 1'b1;
            end else begin
              state_d = KP_DEB_PRESS;
            end
          end else begin
            state_d = KP_IDLE;
          end
        end
        KP_HELD: begin
          if (!cand_valid_i) begin
            cnt_d = 4'd1;
            if (DebN == 4'd1) begin
              state_d = KP_IDLE;
            end else begin
              state_d = KP_DEB_REL;
            end
          end else begin
            state_d = KP_HELD;
          end
        end
        KP_DEB_REL: begin
          if (!cand_valid_i) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == DebN) begin
              state_d = KP_IDLE;
            end else begin
              state_d = KP_DEB_REL;
            end
          end else begin
            state_d = KP_HELD;
          end
        end
        default: begin
          state_d = KP_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

endmodule

// File: rtl/aux_keypad.sv
// 4x4 hex keypad scanner: column scan, row synchronizer, per-sweep candidate
// detection and the 32-bit digit entry register that feeds the aux display.
`ifndef CNT_MILLISEC
`define CNT_MILLISEC 100000
`endif

module aux_keypad
  import aux_keypad_pkg::*;
#(
  parameter int unsigned ScanCntMax    = `CNT_MILLISEC,
  parameter int unsigned DebounceScans = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  input  logic        clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] data
);

  localparam int unsigned     CntW    = (ScanCntMax > 1) ? $clog2(ScanCntMax) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ScanCntMax - 1);

  logic [3:0]      row_meta_q, row_sync_q;
  logic [CntW-1:0] div_q;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      col_n_q;
  logic [1:0]      acc_cnt_q;
  logic [3:0]      acc_code_q;
  logic            key_valid_q;
  logic [3:0]      key_code_q;
  logic [31:0]     data_q;

  logic            tick_s, sweep_end_s;
  logic [3:0]      pressed_s;
  logic [1:0]      col_hits_s, sweep_cnt_s;
  logic [3:0]      sweep_code_s;
  logic            press_s;
  logic [3:0]      press_code_s;

  assign tick_s      = (div_q == CntLast);
  assign sweep_end_s = tick_s && (col_idx_q == 2'd3);
  assign pressed_s   = ~row_sync_q;
  assign col_hits_s  = kp_hit_count(pressed_s);
  assign col_idx_d   = col_idx_q + 2'd1;

  // Fold the current column into the sweep totals; code is only meaningful when the count is one.
  always_comb begin
    sweep_cnt_s = kp_sat_add(acc_cnt_q, col_hits_s);
    if (col_hits_s == 2'd1) begin
      sweep_code_s = {kp_row_index(pressed_s), col_idx_q};
    end else begin
      sweep_code_s = acc_code_q;
    end
  end

  // Row synchronizer; released rows idle high through the pull-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Dwell divider, column drive and sweep accumulator, all advanced by the scan tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      col_n_q    <= 4'b1110;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
    end else if (tick_s) begin
      div_q     <= '0;
      col_idx_q <= col_idx_d;
      col_n_q   <= ~(4'b0001 << col_idx_d);
      if (sweep_end_s) begin
        acc_cnt_q  <= 2'd0;
        acc_code_q <= 4'd0;
      end else begin
        acc_cnt_q  <= sweep_cnt_s;
        acc_code_q <= sweep_code_s;
      end
    end else begin
      div_q <= div_q + CntW'(1);
    end
  end

  keypad_debounce #(
    .DebounceScans(DebounceScans)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .sweep_end_i  (sweep_end_s),
    .cand_valid_i (sweep_cnt_s == 2'd1),
    .cand_code_i  (sweep_code_s),
    .press_o      (press_s),
    .code_o       (press_code_s)
  );

  // Press strobe, held key code and digit entry register; clr wins over a same-cycle shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      data_q      <= 32'd0;
    end else begin
      key_valid_q <= press_s;
      if (press_s) begin
        key_code_q <= press_code_s;
      end
      if (clr) begin
        data_q <= 32'd0;
      end else if (press_s) begin
        data_q <= {data_q[27:0], press_code_s};
      end
    end
  end

  assign col_n     = col_n_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign data      = data_q;

endmodule

// File: tb/tb_aux_keypad.sv
// Directed bench for aux_keypad with a 4-cycle dwell (16-cycle sweep) and 2-sweep debounce.
module tb_aux_keypad;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        clr;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] data;
  logic [15:0] keys;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = 0;

  always #5 clk = ~clk;

  // Switch matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  aux_keypad #(.ScanCntMax(4), .DebounceScans(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .clr       (clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .data      (data)
  );

  // Advance n clocks, sampling 1 time unit after each edge; sweeps end at cyc = 16, 32, ...
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_valid === 1'b1) begin
        pulses++;
        last_pulse = cyc;
      end
    end
  endtask

  task automatic do_reset();
    keys  = 16'h0000;
    clr   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    pulses = 0;
    last_pulse = 0;
  endtask

  task automatic press_release(input int code);
    keys = 16'h0001 << code;
    step(48);
    keys = 16'h0000;
    step(48);
  endtask

  task automatic test_reset();
    keys = 16'h0000;
    clr = 1'b0;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL reset_col_n: got %b expected %b", col_n, 4'b1110); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
  endtask

  task automatic test_single_press();
    do_reset();
    keys = 16'h0001 << 6;
    step(48);
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    checks++; if (last_pulse != 32) begin errors++; $display("FAIL single_latency: got cycle %0d expected 32", last_pulse); end
    checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL single_code: got %h expected 6", key_code); end
    checks++; if (data !== 32'h00000006) begin errors++; $display("FAIL single_data: got %h expected 00000006", data); end
    keys = 16'h0000;
    step(48);
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_release_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_sequence();
    do_reset();
    press_release(1);
    press_release(2);
    press_release(3);
    checks++; if (pulses != 3) begin errors++; $display("FAIL seq_pulses: got %0d expected 3", pulses); end
    checks++; if (data !== 32'h00000123) begin errors++; $display("FAIL seq_data: got %h expected 00000123", data); end
  endtask

  task automatic test_bounce();
    do_reset();
    keys = 16'h0001 << 5;
    step(16);
    keys = 16'h0000;
    step(16);
    checks++; if (pulses != 0) begin errors++; $display("FAIL bounce_early_pulses: got %0d expected 0", pulses); end
    keys = 16'h0001 << 5;
    step(48);
    checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
    checks++; if (last_pulse != 64) begin errors++; $display("FAIL bounce_latency: got cycle %0d expected 64", last_pulse); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL bounce_code: got %h expected 5", key_code); end
  endtask

  // Continues from test_bounce with key 5 still held.
  task automatic test_ghost();
    keys = (16'h0001 << 0) | (16'h0001 << 5);
    step(64);
    checks++; if (pulses != 1) begin errors++; $display("FAIL ghost_pulses: got %0d expected 1", pulses); end
    checks++; if (data !== 32'h00000005) begin errors++; $display("FAIL ghost_data: got %h expected 00000005", data); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL ghost_code: got %h expected 5", key_code); end
    keys = 16'h0000;
    step(32);
  endtask

  task automatic test_no_repeat();
    do_reset();
    keys = 16'h0001 << 4;
    step(160);
    checks++; if (pulses != 1) begin errors++; $display("FAIL repeat_pulses: got %0d expected 1", pulses); end
    keys = 16'h0000;
    step(16);
    keys = 16'h0001 << 4;
    step(48);
    checks++; if (pulses != 1) begin errors++; $display("FAIL glitch_pulses: got %0d expected 1", pulses); end
    checks++; if (data !== 32'h00000004) begin errors++; $display("FAIL glitch_data: got %h expected 00000004", data); end
    keys = 16'h0000;
    step(48);
  endtask

  task automatic test_nine_digits();
    do_reset();
    for (int d = 1; d <= 9; d++) begin
      press_release(d);
    end
    checks++; if (pulses != 9) begin errors++; $display("FAIL nine_pulses: got %0d expected 9", pulses); end
    checks++; if (data !== 32'h23456789) begin errors++; $display("FAIL nine_data: got %h expected 23456789", data); end
  endtask

  // Continues from test_nine_digits: FSM idle, aligned to a sweep boundary.
  task automatic test_clr_with_strobe();
    keys = 16'h0001 << 10;
    step(31);
    clr = 1'b1;
    step(1);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL clr_strobe: got %b expected 1", key_valid); end
    checks++; if (key_code !== 4'hA) begin errors++; $display("FAIL clr_code: got %h expected a", key_code); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL clr_data: got %h expected 0", data); end
    clr = 1'b0;
    step(1);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL clr_strobe_end: got %b expected 0", key_valid); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL clr_data_hold: got %h expected 0", data); end
    keys = 16'h0000;
    step(46);
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_release(3);
    keys = 16'h0001 << 7;
    step(20);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (col_n !== 4'b1110) begin errors++; $display("FAIL mid_col_n: got %b expected %b", col_n, 4'b1110); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_key_valid: got %b expected 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL mid_key_code: got %h expected 0", key_code); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h expected 0", data); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    pulses = 0;
    last_pulse = 0;
    step(48);
    checks++; if (pulses != 1) begin errors++; $display("FAIL mid_rearm_pulses: got %0d expected 1", pulses); end
    checks++; if (last_pulse != 32) begin errors++; $display("FAIL mid_rearm_latency: got cycle %0d expected 32", last_pulse); end
    checks++; if (data !== 32'h00000007) begin errors++; $display("FAIL mid_rearm_data: got %h expected 00000007", data); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_sequence();
    test_bounce();
    test_ghost();
    test_no_repeat();
    test_nine_digits();
    test_clr_with_strobe();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
